// File: rtl/bbox_pixel_walker.sv
// Rasterizer bounding-box consumer: clips a captured bbox to the screen and walks
// its pixels in raster order over a valid/ready stream, with a one-deep bbox queue.
module bbox_pixel_walker #(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] SCREEN_MAX = DATA_W'(255)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bbox_valid,
    input  logic [DATA_W-1:0] bbox_x_min,
    input  logic [DATA_W-1:0] bbox_x_max,
    input  logic [DATA_W-1:0] bbox_y_min,
    input  logic [DATA_W-1:0] bbox_y_max,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_x,
    output logic [DATA_W-1:0] pix_y,
    output logic              pix_last,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] wx_min, wx_max, wy_min, wy_max;
    logic [DATA_W-1:0] qx_min, qx_max, qy_min, qy_max;
    logic              pend_full;
    logic [DATA_W-1:0] x_cnt, y_cnt;

    logic [DATA_W-1:0] cx_min, cx_max, cy_min, cy_max;
    logic              box_empty;
    logic              hs;
    logic              x_end, y_end;
    logic              take_in, take_pend, pend_wr, drop;

    function automatic logic [DATA_W-1:0] clip(input logic [DATA_W-1:0] v);
        return (v > SCREEN_MAX) ? SCREEN_MAX : v;
    endfunction

    assign cx_min    = clip(wx_min);
    assign cx_max    = clip(wx_max);
    assign cy_min    = clip(wy_min);
    assign cy_max    = clip(wy_max);
    assign box_empty = (cx_min > cx_max) || (cy_min > cy_max);

    assign hs    = pix_valid && pix_ready;
    assign x_end = (x_cnt == wx_max);
    assign y_end = (y_cnt == wy_max);

    // A queued bbox is drained from DONE, or from IDLE if it was queued during DONE.
    assign take_pend = pend_full && ((state == DONE) || (state == IDLE));
    assign take_in   = bbox_valid && (state == IDLE) && !pend_full;
    assign pend_wr   = bbox_valid && !take_in && (!pend_full || take_pend);
    assign drop      = bbox_valid && pend_full && !take_pend;

    assign pix_x = x_cnt;
    assign pix_y = y_cnt;
    assign busy  = (state != IDLE) || pend_full;

    // Limit registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (take_pend) begin
            wx_min <= qx_min;
            wx_max <= qx_max;
            wy_min <= qy_min;
            wy_max <= qy_max;
        end else if (take_in) begin
            wx_min <= bbox_x_min;
            wx_max <= bbox_x_max;
            wy_min <= bbox_y_min;
            wy_max <= bbox_y_max;
        end else if (state == LOAD) begin
            wx_min <= cx_min;
            wx_max <= cx_max;
            wy_min <= cy_min;
            wy_max <= cy_max;
        end
        if (pend_wr) begin
            qx_min <= bbox_x_min;
            qx_max <= bbox_x_max;
            qy_min <= bbox_y_min;
            qy_max <= bbox_y_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_full <= 1'b0;
            overrun   <= 1'b0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pend_wr)
                pend_full <= 1'b1;
            else if (take_pend)
                pend_full <= 1'b0;
            if (drop)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (pend_full || bbox_valid)
                        state <= LOAD;
                end
                LOAD: begin
                    if (box_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= SCAN;
                        pix_valid <= 1'b1;
                        x_cnt     <= cx_min;
                        y_cnt     <= cy_min;
                        pix_last  <= (cx_min == cx_max) && (cy_min == cy_max);
                    end
                end
                SCAN: begin
                    if (hs) begin
                        if (!x_end) begin
                            x_cnt    <= x_cnt + DATA_W'(1);
                            pix_last <= ((x_cnt + DATA_W'(1)) == wx_max) && y_end;
                        end else if (!y_end) begin
                            x_cnt    <= wx_min;
                            y_cnt    <= y_cnt + DATA_W'(1);
                            pix_last <= (wx_min == wx_max) && ((y_cnt + DATA_W'(1)) == wy_max);
                        end else begin
                            state     <= DONE;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= pend_full ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
